hilo_mac_unit: RTL and testbench

//  Parametrised HI/LO register file with an iterative multiply/multiply-accumulate engine.

---
 rtl/hilo_pkg.sv | 38 +++
 rtl/mul_iter_core.sv | 41 ++++
 rtl/hilo_mac_unit.sv | 128 ++++++++++++
 tb/tb_hilo_mac_unit.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/hilo_pkg.sv
// Shared types and op-decode helpers for the HI/LO multiply/accumulate unit.
package hilo_pkg;

  typedef enum logic [2:0] {
    MULT  = 3'd0,
    MULTU = 3'd1,
    MADD  = 3'd2,
    MADDU = 3'd3,
    MSUB  = 3'd4,
    MSUBU = 3'd5,
    MTHI  = 3'd6,
    MTLO  = 3'd7
  } op_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MUL    = 2'd1,
    SIGN   = 2'd2,
    COMMIT = 2'd3
  } state_t;

  function automatic logic is_signed(input op_t op);
    return op inside {MULT, MADD, MSUB};
  endfunction

  function automatic logic is_acc(input op_t op);
    return op inside {MADD, MADDU, MSUB, MSUBU};
  endfunction

  function automatic logic is_sub(input op_t op);
    return op inside {MSUB, MSUBU};
  endfunction

  function automatic logic is_mt(input op_t op);
    return op inside {MTHI, MTLO};
  endfunction

endpackage

// File: rtl/mul_iter_core.sv
// Unsigned shift-add multiplier datapath retiring BPC multiplier bits per step.
module mul_iter_core #(
  parameter int XLEN = 32,
  parameter int BPC  = 1
) (
  input  logic              clk,
  input  logic              load_i,
  input  logic              step_i,
  input  logic [XLEN-1:0]   mcand_i,
  input  logic [XLEN-1:0]   mplier_i,
  output logic [2*XLEN-1:0] product_o
);

  logic [2*XLEN-1:0] acc_q;
  logic [2*XLEN-1:0] mcand_q;
  logic [XLEN-1:0]   mplier_q;
  logic [2*XLEN-1:0] partial_d;

  // Sum of the shifted multiplicand for each of the BPC low multiplier bits.
  always_comb begin
    partial_d = '0;
    for (int j = 0; j < BPC; j++) begin
      if (mplier_q[j]) partial_d = partial_d + (mcand_q << j);
    end
  end

  always_ff @(posedge clk) begin
    if (load_i) begin
      acc_q    <= '0;
      mcand_q  <= {{XLEN{1'b0}}, mcand_i};
      mplier_q <= mplier_i;
    end else if (step_i) begin
      acc_q    <= acc_q + partial_d;
      mcand_q  <= mcand_q << BPC;
      mplier_q <= mplier_q >> BPC;
    end
  end

  assign product_o = acc_q;

endmodule

// File: rtl/hilo_mac_unit.sv
// HI/LO register file with iterative MULT/MADD/MSUB engine and direct MTHI/MTLO writes.
// Handshake: start is a level request sampled only in IDLE; the caller holds it until busy=0.
module hilo_mac_unit
  import hilo_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int BPC  = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  op_t             op,
  input  logic [XLEN-1:0] rs_val,
  input  logic [XLEN-1:0] rt_val,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi_out,
  output logic [XLEN-1:0] lo_out,
  output state_t          dbg_state_o
);

  localparam int STEPS = XLEN / BPC;
  localparam int CW    = $clog2(STEPS + 1);

  state_t            state_q;
  op_t               op_q;
  logic              neg_q;
  logic [CW-1:0]     cnt_q;
  logic [2*XLEN-1:0] prod_q;
  logic [XLEN-1:0]   hi_q, lo_q;
  logic              busy_q, done_q;

  logic [XLEN-1:0]   rs_mag, rt_mag;
  logic [2*XLEN-1:0] core_prod;
  logic [2*XLEN-1:0] hilo_d;
  logic              accept;

  // Magnitudes feed the unsigned core; the sign is restored in SIGN.
  assign rs_mag = (is_signed(op) && rs_val[XLEN-1]) ? -rs_val : rs_val;
  assign rt_mag = (is_signed(op) && rt_val[XLEN-1]) ? -rt_val : rt_val;
  assign accept = (state_q == IDLE) && start && !flush;

  mul_iter_core #(.XLEN(XLEN), .BPC(BPC)) u_core (
    .clk       (clk),
    .load_i    (accept && !is_mt(op)),
    .step_i    (state_q == MUL),
    .mcand_i   (rs_mag),
    .mplier_i  (rt_mag),
    .product_o (core_prod)
  );

  always_comb begin
    hilo_d = prod_q;
    if (is_acc(op_q)) begin
      hilo_d = is_sub(op_q) ? ({hi_q, lo_q} - prod_q) : ({hi_q, lo_q} + prod_q);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= MULT;
      neg_q   <= 1'b0;
      cnt_q   <= '0;
      prod_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (op == MTHI) begin
              hi_q   <= rs_val;
              done_q <= 1'b1;
            end else if (op == MTLO) begin
              lo_q   <= rs_val;
              done_q <= 1'b1;
            end else begin
              op_q    <= op;
              neg_q   <= is_signed(op) && (rs_val[XLEN-1] ^ rt_val[XLEN-1]);
              cnt_q   <= '0;
              busy_q  <= 1'b1;
              state_q <= MUL;
            end
          end
        end
        MUL: begin
          if (flush) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (cnt_q == CW'(STEPS - 1)) begin
            state_q <= SIGN;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        SIGN: begin
          if (flush) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            prod_q  <= neg_q ? -core_prod : core_prod;
            busy_q  <= 1'b0;
            state_q <= COMMIT;
          end
        end
        COMMIT: begin
          // The instruction has already retired, so flush cannot cancel this write.
          {hi_q, lo_q} <= hilo_d;
          done_q       <= 1'b1;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign hi_out      = hi_q;
  assign lo_out      = lo_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_hilo_mac_unit.sv
// Directed bench for hilo_mac_unit: one BPC=1 instance plus BPC=2 and BPC=4 instances in lockstep.
module tb_hilo_mac_unit;
  import hilo_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_m, start_w;
  op_t         op_r;
  logic [31:0] rs, rt;
  logic        flush, flush_w;

  logic [2:0]  busy_v, done_v;
  logic [31:0] hi_v [3];
  logic [31:0] lo_v [3];
  state_t      st_v [3];

  int          n_checks = 0;
  int          n_errors = 0;
  logic [63:0] exp_hilo;
  int          bpc_tab [3] = '{1, 2, 4};

  always #5 clk = ~clk;

  hilo_mac_unit #(.XLEN(32), .BPC(1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start_m), .op(op_r), .rs_val(rs), .rt_val(rt),
    .flush(flush), .busy(busy_v[0]), .done(done_v[0]), .hi_out(hi_v[0]), .lo_out(lo_v[0]),
    .dbg_state_o(st_v[0]));

  hilo_mac_unit #(.XLEN(32), .BPC(2)) u_dut2 (
    .clk(clk), .reset(reset), .start(start_w), .op(op_r), .rs_val(rs), .rt_val(rt),
    .flush(flush_w), .busy(busy_v[1]), .done(done_v[1]), .hi_out(hi_v[1]), .lo_out(lo_v[1]),
    .dbg_state_o(st_v[1]));

  hilo_mac_unit #(.XLEN(32), .BPC(4)) u_dut4 (
    .clk(clk), .reset(reset), .start(start_w), .op(op_r), .rs_val(rs), .rt_val(rt),
    .flush(flush_w), .busy(busy_v[2]), .done(done_v[2]), .hi_out(hi_v[2]), .lo_out(lo_v[2]),
    .dbg_state_o(st_v[2]));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: full 64-bit products computed directly, then applied to {HI,LO}.
  function automatic logic [63:0] ref_mac(input op_t o, input logic [31:0] a,
                                          input logic [31:0] b, input logic [63:0] cur);
    logic [63:0] p;
    longint      sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (is_signed(o)) p = 64'(sa * sb);
    else              p = {32'd0, a} * {32'd0, b};
    case (o)
      MULT, MULTU: return p;
      MADD, MADDU: return cur + p;
      MSUB, MSUBU: return cur - p;
      MTHI:        return {a, cur[31:0]};
      default:     return {cur[63:32], a};
    endcase
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    exp_hilo = '0;
  endtask

  // Issue one op to all three instances, then check latency, busy length and HI/LO.
  task automatic do_op(input op_t o, input logic [31:0] a, input logic [31:0] b, input string tag);
    int lat [3];
    int bc  [3];
    int exp_lat, exp_bc;
    @(negedge clk);
    op_r = o; rs = a; rt = b; start_m = 1'b1; start_w = 1'b1;
    @(posedge clk); #1;
    start_m = 1'b0; start_w = 1'b0;
    for (int i = 0; i < 3; i++) begin lat[i] = -1; bc[i] = 0; end
    for (int c = 0; c < 100; c++) begin
      for (int i = 0; i < 3; i++) begin
        if (lat[i] < 0) begin
          if (busy_v[i]) bc[i]++;
          if (done_v[i]) lat[i] = c;
        end
      end
      if (lat[0] >= 0 && lat[1] >= 0 && lat[2] >= 0) break;
      @(posedge clk); #1;
    end
    exp_hilo = ref_mac(o, a, b, exp_hilo);
    for (int i = 0; i < 3; i++) begin
      exp_lat = is_mt(o) ? 0 : 32 / bpc_tab[i] + 2;
      exp_bc  = is_mt(o) ? 0 : 32 / bpc_tab[i] + 1;
      check($sformatf("%s_lat_bpc%0d", tag, bpc_tab[i]), 64'(lat[i]), 64'(exp_lat));
      check($sformatf("%s_busy_bpc%0d", tag, bpc_tab[i]), 64'(bc[i]), 64'(exp_bc));
      check($sformatf("%s_hilo_bpc%0d", tag, bpc_tab[i]), {hi_v[i], lo_v[i]}, exp_hilo);
    end
  endtask

  initial begin
    int dn;
    reset = 1'b1; start_m = 1'b0; start_w = 1'b0; flush = 1'b0; flush_w = 1'b0;
    op_r = MULT; rs = '0; rt = '0;
    do_reset();

    // Reset state
    @(negedge clk);
    check("rst_hi", {32'd0, hi_v[0]}, 64'd0);
    check("rst_lo", {32'd0, lo_v[0]}, 64'd0);
    check("rst_busy", {61'd0, busy_v}, 64'd0);
    check("rst_done", {61'd0, done_v}, 64'd0);
    check("rst_state", {62'd0, st_v[0]}, {62'd0, IDLE});

    // 1: largest unsigned product
    do_op(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "t1");
    check("t1_hilo_const", {hi_v[0], lo_v[0]}, 64'hFFFF_FFFE_0000_0001);

    // 2: signed multiply, then accumulate
    do_op(MULT, 32'hFFFF_FFFD, 32'd7, "t2a");
    check("t2a_hilo_const", {hi_v[0], lo_v[0]}, 64'hFFFF_FFFF_FFFF_FFEB);
    do_op(MADD, 32'd5, 32'd5, "t2b");
    check("t2b_hilo_const", {hi_v[0], lo_v[0]}, 64'h0000_0000_0000_0004);

    // 3: direct writes then subtract-accumulate across the HI/LO boundary
    do_op(MTHI, 32'h1, 32'h0, "t3hi");
    do_op(MTLO, 32'h0, 32'h0, "t3lo");
    do_op(MSUBU, 32'd1, 32'd1, "t3");
    check("t3_hilo_const", {hi_v[2], lo_v[2]}, 64'h0000_0000_FFFF_FFFF);

    // 4: flush mid-MUL on the BPC=1 instance, with an ignored MTHI during busy
    @(negedge clk);
    op_r = MULTU; rs = 32'h1234; rt = 32'h5678; start_m = 1'b1;
    @(posedge clk); #1;
    start_m = 1'b0; dn = 0;
    for (int c = 0; c < 60; c++) begin
      if (done_v[0]) dn++;
      if (c == 5) begin op_r = MTHI; rs = 32'hDEAD_BEEF; start_m = 1'b1; end
      if (c == 6) start_m = 1'b0;
      if (c == 9) check("t4_busy_before", {63'd0, busy_v[0]}, 64'd1);
      if (c == 10) flush = 1'b1;
      if (c == 11) begin
        flush = 1'b0;
        check("t4_busy_after", {63'd0, busy_v[0]}, 64'd0);
      end
      @(posedge clk); #1;
    end
    check("t4_no_done", 64'(dn), 64'd0);
    check("t4_hilo_kept", {hi_v[0], lo_v[0]}, 64'h0000_0000_FFFF_FFFF);

    // 5: reset in the middle of MUL
    @(negedge clk);
    op_r = MULTU; rs = 32'hABCD; rt = 32'h1111; start_m = 1'b1;
    @(posedge clk); #1;
    start_m = 1'b0; dn = 0;
    for (int c = 0; c < 50; c++) begin
      if (c == 5) reset = 1'b1;
      if (c == 6) begin
        reset = 1'b0;
        check("t5_hilo_zero", {hi_v[0], lo_v[0]}, 64'd0);
        check("t5_busy", {61'd0, busy_v}, 64'd0);
        check("t5_state", {62'd0, st_v[0]}, {62'd0, IDLE});
        check("t5_w_hilo_zero", {hi_v[1], lo_v[2]}, 64'd0);
      end
      if (c >= 6 && done_v[0]) dn++;
      @(posedge clk); #1;
    end
    check("t5_no_done", 64'(dn), 64'd0);
    exp_hilo = '0;
    do_op(MULT, 32'd2, 32'd3, "t5b");
    check("t5b_lo_const", {hi_v[0], lo_v[0]}, 64'd6);

    // Extreme signed magnitudes
    do_op(MULT, 32'h8000_0000, 32'h8000_0000, "t6min");
    check("t6min_const", {hi_v[1], lo_v[1]}, 64'h4000_0000_0000_0000);
    do_op(MSUB, 32'h8000_0000, 32'h0000_0001, "t6msub");
    check("t6msub_const", {hi_v[0], lo_v[0]}, 64'h4000_0000_8000_0000);

    // 6: randomised op mix against the reference model
    for (int n = 0; n < 12; n++) begin
      do_op(op_t'($urandom_range(0, 7)), $urandom, $urandom, $sformatf("rnd%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
